// File: rtl/ahb_pkg.sv
// Shared AHB encodings, FSM state type and byte-lane helper
// for the SRAM subordinate.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } ahb_state_t;

  // Little-endian lane enables for an aligned access.
  function automatic logic [3:0] lane_mask(
    input logic [2:0] size,
    input logic [1:0] a
  );
    logic [3:0] m;
    m = 4'b1111;
    if (size == HSIZE_BYTE)
      m = 4'b0001 << a;
    else if (size == HSIZE_HALF)
      m = a[1] ? 4'b1100 : 4'b0011;
    return m;
  endfunction

endpackage

// File: rtl/ahb_sub_mem.sv
// Word-wide single-port SRAM model, byte write enables, async read.
// Ports: clk, we, be[3:0], addr (word index), wdata, rdata.
module ahb_sub_mem #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k])
          mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB subordinate fronting a word SRAM with wait states and 2-cycle ERROR.
// Ports: i_HCLK/i_HRESETn, AHB address/data inputs, o_HRDATA/o_HREADYOUT/o_HRESP.
module ahb_sram_subordinate
  import ahb_pkg::*;
#(
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        i_HCLK,
  input  logic        i_HRESETn,
  input  logic        i_HSEL,
  input  logic [31:0] i_HADDR,
  input  logic [1:0]  i_HTRANS,
  input  logic        i_HWRITE,
  input  logic [2:0]  i_HSIZE,
  input  logic [2:0]  i_HBURST,
  input  logic [3:0]  i_HPROT,
  input  logic [31:0] i_HWDATA,
  input  logic        i_HREADY,
  output logic [31:0] o_HRDATA,
  output logic        o_HREADYOUT,
  output logic [1:0]  o_HRESP
);

  localparam int AW =
    (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CW =
    (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  ahb_state_t    state;
  ahb_state_t    nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q;
  logic          write_q;
  logic [2:0]    size_q;
  logic          active;
  logic          accept;
  logic          oob;
  logic          err;
  logic          mem_we;
  logic [31:0]   rd_word;
  logic          ready_q;
  logic [1:0]    resp_q;
  logic          unused;

  always_comb begin
    active = 1'b0;
    unique case (i_HTRANS)
      HTRANS_NONSEQ,
      HTRANS_SEQ:    active = 1'b1;
      HTRANS_IDLE,
      HTRANS_BUSY:   active = 1'b0;
    endcase
  end

  // New address phases are only taken while HREADYOUT is high.
  assign accept = i_HSEL && i_HREADY && active &&
                  (state inside {S_IDLE, S_DATA, S_ERR2});

  assign oob = {2'b00, i_HADDR[31:2]} >= 32'(MEM_WORDS);

  assign err = (i_HSIZE > HSIZE_WORD) ||
               (i_HSIZE == HSIZE_HALF && i_HADDR[0]) ||
               (i_HSIZE == HSIZE_WORD && |i_HADDR[1:0]) ||
               oob;

  always_comb begin
    nxt = S_IDLE;
    unique case (state)
      S_WAIT:
        nxt = (cnt == CW'(1)) ? S_DATA : S_WAIT;
      S_ERR1:
        nxt = S_ERR2;
      default:
        if (accept)
          nxt = err ? S_ERR1 :
                (WAIT_STATES > 0) ? S_WAIT : S_DATA;
    endcase
  end

  always_ff @(posedge i_HCLK) begin
    if (!i_HRESETn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= HSIZE_BYTE;
      ready_q <= 1'b1;
      resp_q  <= HRESP_OKAY;
    end else begin
      state   <= nxt;
      ready_q <= !(nxt inside {S_WAIT, S_ERR1});
      resp_q  <= (nxt inside {S_ERR1, S_ERR2}) ?
                 HRESP_ERROR : HRESP_OKAY;
      if (state == S_WAIT)
        cnt <= cnt - 1'b1;
      else if (nxt == S_WAIT)
        cnt <= CW'(WAIT_STATES);
      if (accept) begin
        addr_q  <= i_HADDR;
        write_q <= i_HWRITE;
        size_q  <= i_HSIZE;
      end
    end
  end

  // Reset in the completing cycle blocks the commit.
  assign mem_we = (state == S_DATA) && write_q && i_HRESETn;

  ahb_sub_mem #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_mem (
    .clk   (i_HCLK),
    .we    (mem_we),
    .be    (lane_mask(size_q, addr_q[1:0])),
    .addr  (addr_q[AW+1:2]),
    .wdata (i_HWDATA),
    .rdata (rd_word)
  );

  assign o_HRDATA =
    (!write_q && (state inside {S_WAIT, S_DATA})) ?
    rd_word : '0;
  assign o_HREADYOUT = ready_q;
  assign o_HRESP     = resp_q;

  assign unused = ^{i_HBURST, i_HPROT, addr_q[31:AW+2]};

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Self-checking bench: two instances (1 and 0 wait states),
// directed scenarios plus random transfers vs a word-array model.
module tb_ahb_sram_subordinate;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel    [2];
  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [31:0] hwdata [2];
  logic        hready [2];
  logic [31:0] hrdata [2];
  logic        rdy    [2];
  logic [1:0]  resp   [2];
  logic [2:0]  hburst = 3'b000;
  logic [3:0]  hprot  = 4'b0011;

  int          errors = 0;
  int          checks = 0;
  int          ws_of  [2] = '{1, 0};
  logic [31:0] ref_mem [2][256];
  logic [31:0] rd;
  logic [31:0] v;

  always #5 clk = ~clk;

  assign hready[0] = rdy[0];
  assign hready[1] = rdy[1];

  ahb_sram_subordinate #(
    .MEM_WORDS   (256),
    .WAIT_STATES (1)
  ) u_ws1 (
    .i_HCLK      (clk),
    .i_HRESETn   (rst_n),
    .i_HSEL      (sel[0]),
    .i_HADDR     (haddr[0]),
    .i_HTRANS    (htrans[0]),
    .i_HWRITE    (hwrite[0]),
    .i_HSIZE     (hsize[0]),
    .i_HBURST    (hburst),
    .i_HPROT     (hprot),
    .i_HWDATA    (hwdata[0]),
    .i_HREADY    (hready[0]),
    .o_HRDATA    (hrdata[0]),
    .o_HREADYOUT (rdy[0]),
    .o_HRESP     (resp[0])
  );

  ahb_sram_subordinate #(
    .MEM_WORDS   (256),
    .WAIT_STATES (0)
  ) u_ws0 (
    .i_HCLK      (clk),
    .i_HRESETn   (rst_n),
    .i_HSEL      (sel[1]),
    .i_HADDR     (haddr[1]),
    .i_HTRANS    (htrans[1]),
    .i_HWRITE    (hwrite[1]),
    .i_HSIZE     (hsize[1]),
    .i_HBURST    (hburst),
    .i_HPROT     (hprot),
    .i_HWDATA    (hwdata[1]),
    .i_HREADY    (hready[1]),
    .o_HRDATA    (hrdata[1]),
    .o_HREADYOUT (rdy[1]),
    .o_HRESP     (resp[1])
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_out(
    input string       tag,
    input int          d,
    input logic        e_rdy,
    input logic [1:0]  e_resp,
    input logic [31:0] e_data
  );
    chk({tag, "_rdy"}, 32'(rdy[d]), 32'(e_rdy));
    chk({tag, "_resp"}, 32'(resp[d]), 32'(e_resp));
    chk({tag, "_data"}, hrdata[d], e_data);
  endtask

  task automatic go_idle(input int d);
    sel[d]    = 1'b0;
    htrans[d] = 2'b00;
  endtask

  // One non-pipelined transfer; checks every data-phase cycle.
  task automatic xfer(
    input  int          d,
    input  logic [31:0] a,
    input  logic        w,
    input  logic [2:0]  sz,
    input  logic [31:0] wd,
    output logic [31:0] rdv
  );
    int          nb;
    int          wi;
    int          lane;
    int          low;
    int          exp_low;
    bit          err;
    bit          done;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rd;
    nb  = 1 << sz;
    wi  = int'(a >> 2);
    err = (sz > 3'd2) || ((a % nb) != 0) ||
          (wi >= 256);
    exp_rd   = (err || w) ? 32'h0 : ref_mem[d][wi];
    exp_low  = err ? 1 : ws_of[d];
    exp_resp = err ? 2'b01 : 2'b00;
    if (!err && w) begin
      for (int k = 0; k < nb; k++) begin
        lane = int'(a % 4) + k;
        ref_mem[d][wi][8*lane +: 8] = wd[8*lane +: 8];
      end
    end
    @(negedge clk);
    sel[d]    = 1'b1;
    htrans[d] = 2'b10;
    haddr[d]  = a;
    hwrite[d] = w;
    hsize[d]  = sz;
    @(posedge clk);
    #1;
    go_idle(d);
    haddr[d]  = $urandom;
    hwdata[d] = wd;
    low  = 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (rdy[d]) begin
        done = 1;
      end else begin
        low++;
        chk("wait_resp", 32'(resp[d]), 32'(exp_resp));
        chk("wait_data", hrdata[d], exp_rd);
      end
    end
    chk("completed", 32'(done), 32'd1);
    chk("low_cycles", 32'(low), 32'(exp_low));
    chk("end_resp", 32'(resp[d]), 32'(exp_resp));
    chk("end_data", hrdata[d], exp_rd);
    rdv = hrdata[d];
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      go_idle(d);
      haddr[d]  = '0;
      hwrite[d] = 1'b0;
      hsize[d]  = 3'b010;
      hwdata[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_out("reset0", 0, 1'b1, 2'b00, 32'h0);
    chk_out("reset1", 1, 1'b1, 2'b00, 32'h0);
    rst_n = 1'b1;

    // Word write then read with one wait state.
    xfer(0, 32'h10, 1'b1, 3'b010, 32'hDEADBEEF, rd);
    xfer(0, 32'h10, 1'b0, 3'b010, 32'h0, rd);
    chk("word_rd", rd, 32'hDEADBEEF);

    // Byte lanes.
    xfer(0, 32'h20, 1'b1, 3'b010, 32'h11223344, rd);
    xfer(0, 32'h22, 1'b1, 3'b000, 32'h00AA0000, rd);
    xfer(0, 32'h20, 1'b1, 3'b001, 32'h00005566, rd);
    xfer(0, 32'h20, 1'b0, 3'b010, 32'h0, rd);
    chk("lanes_rd", rd, 32'h11AA5566);

    // Errors leave memory untouched.
    xfer(0, 32'h02, 1'b0, 3'b010, 32'h0, rd);
    xfer(0, 32'h12, 1'b1, 3'b010, 32'h0BADF00D, rd);
    xfer(0, 32'h400, 1'b1, 3'b010, 32'h0BADF00D, rd);
    xfer(0, 32'h10, 1'b1, 3'b011, 32'h0BADF00D, rd);
    xfer(0, 32'h11, 1'b1, 3'b001, 32'h0BADF00D, rd);
    xfer(0, 32'h10, 1'b0, 3'b010, 32'h0, rd);
    chk("err_untouched", rd, 32'hDEADBEEF);
    xfer(1, 32'h402, 1'b0, 3'b000, 32'h0, rd);

    // Pipelined write then read, zero wait states.
    v = 32'hA5C3_0F96;
    @(negedge clk);
    sel[1]    = 1'b1;
    htrans[1] = 2'b10;
    haddr[1]  = 32'h0;
    hwrite[1] = 1'b1;
    hsize[1]  = 3'b010;
    @(posedge clk);
    #1;
    hwdata[1] = v;
    hwrite[1] = 1'b0;
    @(negedge clk);
    chk_out("pipe_wr", 1, 1'b1, 2'b00, 32'h0);
    @(posedge clk);
    #1;
    go_idle(1);
    ref_mem[1][0] = v;
    @(negedge clk);
    chk_out("pipe_rd", 1, 1'b1, 2'b00, v);
    @(posedge clk);
    #1;

    // IDLE and BUSY with HSEL, NONSEQ without HSEL.
    @(negedge clk);
    sel[0]    = 1'b1;
    htrans[0] = 2'b00;
    @(posedge clk);
    #1;
    htrans[0] = 2'b01;
    @(negedge clk);
    chk_out("idle_sel", 0, 1'b1, 2'b00, 32'h0);
    @(posedge clk);
    #1;
    sel[0]    = 1'b0;
    htrans[0] = 2'b10;
    haddr[0]  = 32'h10;
    hwrite[0] = 1'b0;
    @(negedge clk);
    chk_out("busy_sel", 0, 1'b1, 2'b00, 32'h0);
    @(posedge clk);
    #1;
    go_idle(0);
    @(negedge clk);
    chk_out("desel", 0, 1'b1, 2'b00, 32'h0);

    // Reset during S_WAIT of a write.
    xfer(0, 32'h30, 1'b1, 3'b010, 32'hCAFEF00D, rd);
    @(negedge clk);
    sel[0]    = 1'b1;
    htrans[0] = 2'b10;
    haddr[0]  = 32'h30;
    hwrite[0] = 1'b1;
    hsize[0]  = 3'b010;
    @(posedge clk);
    #1;
    go_idle(0);
    hwdata[0] = 32'h12345678;
    @(negedge clk);
    chk("rst_wait_rdy", 32'(rdy[0]), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_out("rst_wait", 0, 1'b1, 2'b00, 32'h0);
    rst_n = 1'b1;
    xfer(0, 32'h30, 1'b0, 3'b010, 32'h0, rd);
    chk("rst_wait_keep", rd, 32'hCAFEF00D);

    // Reset during the committing S_DATA cycle.
    xfer(1, 32'h34, 1'b1, 3'b010, 32'h600DCAFE, rd);
    @(negedge clk);
    sel[1]    = 1'b1;
    htrans[1] = 2'b10;
    haddr[1]  = 32'h34;
    hwrite[1] = 1'b1;
    hsize[1]  = 3'b010;
    @(posedge clk);
    #1;
    go_idle(1);
    hwdata[1] = 32'h87654321;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_out("rst_data", 1, 1'b1, 2'b00, 32'h0);
    rst_n = 1'b1;
    xfer(1, 32'h34, 1'b0, 3'b010, 32'h0, rd);
    chk("rst_data_keep", rd, 32'h600DCAFE);

    // Random traffic against the model.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++)
        xfer(d, 32'(4 * i), 1'b1, 3'b010, $urandom, rd);
      for (int n = 0; n < 60; n++) begin
        logic [31:0] a;
        logic [2:0]  sz;
        sz = 3'($urandom_range(0, 3));
        if (sz == 3'd3)
          sz = 3'($urandom_range(3, 7));
        if ($urandom_range(0, 9) == 0)
          a = 32'h400 + 32'($urandom_range(0, 1023));
        else
          a = 32'(4 * $urandom_range(0, 15)) +
              32'($urandom_range(0, 3));
        xfer(d, a, 1'($urandom), sz, $urandom, rd);
      end
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
